// File: rtl/instr_ctrl.sv
// instr_ctrl: fetches 16-bit instruction words over a req/ack port and decodes them for DataPath.
// Optional macro INSTR_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the core instead of executing as NOP.

package alu;
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } AluCmd;
endpackage

package ctrl;
  typedef struct packed {
    logic reg_wr_en;
    logic dst_in_sel;
  } CtrlSig;
endpackage

module instr_ctrl #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [11:0]       operands,
  output alu::AluCmd        alu_cmd,
  output ctrl::CtrlSig      ctrl_sig,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(1'b1);

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [11:0]     operands_r, operands_s;
  alu::AluCmd      alu_cmd_r, alu_cmd_s;
  logic            wr_en_r, wr_en_s;
  logic            sel_r, sel_s;
  logic            illegal_r, illegal_s;
  logic            halt_op_r, halt_op_s;
  logic            req_r;
  logic            busy_r;
  logic            halted_r;

  // Next-state, PC update and instruction decode
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    operands_s = operands_r;
    alu_cmd_s  = alu_cmd_r;
    sel_s      = sel_r;
    wr_en_s    = 1'b0;
    illegal_s  = illegal_r;
    halt_op_s  = halt_op_r;
    case (state_r)
      IDLE, HALT: begin
        if (start) begin
          state_s   = FETCH;
          pc_s      = RESET_PC;
          illegal_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_s    = EXEC;
          operands_s = imem_data[11:0];
          halt_op_s  = 1'b0;
          // Decoded values are captured here so EXEC drives them straight from registers
          case (imem_data[15:12])
            4'h0: wr_en_s = 1'b0;
            4'h1: begin
              wr_en_s = 1'b1;
              sel_s   = 1'b1;
            end
            4'h2: begin
              wr_en_s   = 1'b1;
              sel_s     = 1'b0;
              alu_cmd_s = alu::ADD;
            end
            4'h3: begin
              wr_en_s   = 1'b1;
              sel_s     = 1'b0;
              alu_cmd_s = alu::SUB;
            end
            4'h4: begin
              wr_en_s   = 1'b1;
              sel_s     = 1'b0;
              alu_cmd_s = alu::AND;
            end
            4'h5: begin
              wr_en_s   = 1'b1;
              sel_s     = 1'b0;
              alu_cmd_s = alu::OR;
            end
            4'hF: halt_op_s = 1'b1;
            default: begin
              illegal_s = 1'b1;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
              halt_op_s = 1'b1;
`else
              halt_op_s = 1'b0;
`endif
            end
          endcase
        end else begin
          state_s = FETCH;
        end
      end
      EXEC: begin
        if (halt_op_r) begin
          state_s = HALT;
        end else begin
          state_s = FETCH;
          pc_s    = pc_r + PC_STEP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, PC and output registers; status outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      operands_r <= 12'h000;
      alu_cmd_r  <= alu::ADD;
      wr_en_r    <= 1'b0;
      sel_r      <= 1'b0;
      illegal_r  <= 1'b0;
      halt_op_r  <= 1'b0;
      req_r      <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      operands_r <= operands_s;
      alu_cmd_r  <= alu_cmd_s;
      wr_en_r    <= wr_en_s;
      sel_r      <= sel_s;
      illegal_r  <= illegal_s;
      halt_op_r  <= halt_op_s;
      req_r      <= (state_s == FETCH);
      busy_r     <= (state_s == FETCH) || (state_s == EXEC);
      halted_r   <= (state_s == HALT);
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign operands  = operands_r;
  assign alu_cmd   = alu_cmd_r;
  assign ctrl_sig  = '{reg_wr_en: wr_en_r, dst_in_sel: sel_r};
  assign busy      = busy_r;
  assign halted    = halted_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_instr_ctrl.sv
// Scoreboard bench for instr_ctrl: a program-level reference model predicts fetch addresses,
// register writes and final status; a negedge monitor/memory responder compares them.
module tb_instr_ctrl;
  localparam int PCW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ack;
  logic [15:0]    imem_data;
  logic [11:0]    operands;
  alu::AluCmd     alu_cmd;
  ctrl::CtrlSig   ctrl_sig;
  logic           busy;
  logic           halted;
  logic           illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]    mem_q[$];
  int             wait_q[$];
  logic [PCW-1:0] exp_addr_q[$];
  logic [14:0]    exp_wr_q[$];
  int             waited = 0;
  int             req_run = 0;
  int             m_last_alu = 0;

  always #5 clk = ~clk;

  instr_ctrl #(.PC_W(PCW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .operands(operands), .alu_cmd(alu_cmd), .ctrl_sig(ctrl_sig),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor compares outputs, then the memory responder drives ack/data for the next edge
  always @(negedge clk) begin
    logic [14:0] got_w;
    if (rst) begin
      imem_ack  = 1'b0;
      imem_data = 16'h0000;
      waited    = 0;
      req_run   = 0;
    end else begin
      if (ctrl_sig.reg_wr_en) begin
        check("busy_in_exec", 32'(busy), 32'd1);
        got_w = {operands, alu_cmd, ctrl_sig.dst_in_sel};
        if (exp_wr_q.size() == 0) fail_now("unexpected_write");
        else check("write", 32'(got_w), 32'(exp_wr_q.pop_front()));
      end
      if (imem_req) begin
        req_run++;
        check("fetch_no_write", 32'(ctrl_sig.reg_wr_en), 32'd0);
        check("busy_in_fetch", 32'(busy), 32'd1);
        if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
        else check("fetch_addr", 32'(imem_addr), 32'(exp_addr_q[0]));
        if (mem_q.size() > 0 && waited >= wait_q[0]) begin
          check("req_held_cycles", 32'(req_run), 32'(wait_q[0] + 1));
          imem_ack  = 1'b1;
          imem_data = mem_q.pop_front();
          wait_q.delete(0);
          if (exp_addr_q.size() > 0) exp_addr_q.delete(0);
          waited  = 0;
          req_run = 0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 16'($urandom);
          if (mem_q.size() > 0) waited++;
        end
      end else begin
        req_run   = 0;
        imem_ack  = 1'($urandom);
        imem_data = 16'($urandom);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_operands", 32'(operands), 32'd0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    check("rst_ctrl_sig", 32'(ctrl_sig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check_reset_vals();
    mem_q.delete();
    wait_q.delete();
    exp_addr_q.delete();
    exp_wr_q.delete();
    m_last_alu = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input logic [15:0] prog[$], input int waits[$], input bit lat);
    int          pc = 0;
    bit          ill = 1'b0;
    bit          done = 1'b0;
    int          budget;
    logic [11:0] opnd = 12'h000;
    logic [3:0]  op;
    // Program-level model: walk the instruction list the way the controller should
    for (int i = 0; i < prog.size(); i++) begin
      if (!done) begin
        op = prog[i][15:12];
        exp_addr_q.push_back(PCW'(pc));
        mem_q.push_back(prog[i]);
        wait_q.push_back(waits[i]);
        opnd = prog[i][11:0];
        if (op == 4'h1) begin
          exp_wr_q.push_back({opnd, 2'(m_last_alu), 1'b1});
        end else if (op >= 4'h2 && op <= 4'h5) begin
          m_last_alu = int'(op) - 2;
          exp_wr_q.push_back({opnd, 2'(m_last_alu), 1'b0});
        end else if (op == 4'hF) begin
          done = 1'b1;
        end else if (op != 4'h0) begin
          ill = 1'b1;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
          done = 1'b1;
`endif
        end
        if (!done) pc = (pc + 1) % (1 << PCW);
      end
    end
    budget = 6 * prog.size() + 10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_clears_illegal", 32'(illegal), 32'd0);
    check("start_req", 32'(imem_req), 32'd1);
    if (lat) begin
      check("lat_addr", 32'(imem_addr), 32'd0);
      @(posedge clk);
      #1;
      check("lat_exec_wr", 32'(ctrl_sig.reg_wr_en), 32'd1);
      check("lat_operands", 32'(operands), 32'h114);
      check("lat_dst_in_sel", 32'(ctrl_sig.dst_in_sel), 32'd1);
      @(posedge clk);
      #1;
      check("lat_wr_drop", 32'(ctrl_sig.reg_wr_en), 32'd0);
      check("lat_next_addr", 32'(imem_addr), 32'd1);
      check("lat_next_req", 32'(imem_req), 32'd1);
    end
    while (!halted && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!halted) fail_now("halt_timeout");
    check("end_halted", 32'(halted), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_req", 32'(imem_req), 32'd0);
    check("end_illegal", 32'(illegal), 32'(ill));
    check("end_pc", 32'(imem_addr), 32'(pc));
    check("end_operands", 32'(operands), 32'(opnd));
    check("end_fetch_queue", 32'(exp_addr_q.size()), 32'd0);
    check("end_write_queue", 32'(exp_wr_q.size()), 32'd0);
    if (!halted) do_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] prog[$];
    int          waits[$];
    int          n;
    rst   = 1'b0;
    start = 1'b0;
    #0;
    do_reset();

    prog = {16'h1114, 16'hF000};
    waits = {0, 0};
    run_prog(prog, waits, 1'b1);

    prog = {16'h1114, 16'h130A, 16'h2513, 16'hF000};
    waits = {0, 0, 0, 0};
    run_prog(prog, waits, 1'b0);

    prog = {16'h3ABC, 16'h4123, 16'hF000};
    waits = {3, 1, 2};
    run_prog(prog, waits, 1'b0);

    prog = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF000};
    waits = {0, 0, 0, 0, 0};
    run_prog(prog, waits, 1'b0);

    prog = {16'h7000, 16'hF000};
    waits = {0, 0};
    run_prog(prog, waits, 1'b0);

    prog = {16'h5FFF, 16'hF000};
    waits = {1, 0};
    run_prog(prog, waits, 1'b0);

    // Reset while a fetch is outstanding, then restart from the reset address
    do_reset();
    mem_q.push_back(16'h1114);
    wait_q.push_back(0);
    exp_addr_q.push_back(PCW'(0));
    exp_addr_q.push_back(PCW'(1));
    exp_wr_q.push_back({12'h114, 2'd0, 1'b1});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_req", 32'(imem_req), 32'd1);
    check("hold_addr", 32'(imem_addr), 32'd1);
    check("hold_operands", 32'(operands), 32'h114);
    #2;
    do_reset();
    prog = {16'hF000};
    waits = {0};
    run_prog(prog, waits, 1'b0);

    for (int r = 0; r < 25; r++) begin
      prog.delete();
      waits.delete();
      n = int'($urandom_range(1, 9));
      for (int k = 0; k < n; k++) begin
        prog.push_back({4'($urandom_range(0, 14)), 12'($urandom)});
        waits.push_back(int'($urandom_range(0, 3)));
      end
      prog.push_back({4'hF, 12'($urandom)});
      waits.push_back(int'($urandom_range(0, 3)));
      run_prog(prog, waits, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_ctrl.md
# instr_ctrl

Instruction fetch/decode controller driving the `DataPath` control side. It fetches 16-bit instruction words over a request/acknowledge memory port and decodes each into `operands`, `alu_cmd` and `ctrl_sig`. It pulses the register-file write for exactly one cycle per instruction. It sits between instruction memory and `DataPath`, and is the producer of the signals `DataPath` consumes.

## Interface
- `PC_W`, default 8: program counter / instruction address width.
- `RESET_PC`, default 0: address of the first fetched instruction after reset or restart.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin execution; sampled only in IDLE or HALT.
- `imem_req`  out  1: fetch request; held high until acknowledged.
- `imem_addr`  out  PC_W: fetch address (current PC).
- `imem_ack`  in  1: memory acknowledge; `imem_data` is valid in the same cycle.
- `imem_data`  in  16: instruction word; `[15:12]` opcode, `[11:0]` operand field.
- `operands`  out  12: operand field to `DataPath`.
- `alu_cmd`  out  `alu::AluCmd`: ALU operation to `DataPath`.
- `ctrl_sig`  out  `ctrl::CtrlSig`: `reg_wr_en` and `dst_in_sel` to `DataPath`.
- `busy`  out  1: high in FETCH and EXEC.
- `halted`  out  1: high in HALT.
- `illegal`  out  1: sticky flag, set on an undefined opcode; cleared by `rst` or by an accepted `start`.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - `start`=1 → FETCH, with PC=`RESET_PC`.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC.
  - On `imem_req && imem_ack`: capture `imem_data`, decode it, → EXEC.
  - `imem_req` stays high across any number of wait cycles.
- EXEC (one cycle): decoded outputs are driven. Exit behaviour:
  - HALT opcode → HALT.
  - Otherwise PC←PC+1 and → FETCH.
- Decode, opcode `[15:12]`:
  - 0x0 NOP: `reg_wr_en`=0.
  - 0x1 INIT, `{dst[3:0], imm[7:0]}`: `reg_wr_en`=1, `dst_in_sel`=1.
  - 0x2 ADD / 0x3 SUB / 0x4 AND / 0x5 OR, `{dst, src1, src2}`: `reg_wr_en`=1, `dst_in_sel`=0, `alu_cmd`=`alu::ADD`/`SUB`/`AND`/`OR`.
  - 0xF HALT: `reg_wr_en`=0.
  - Any other opcode: set `illegal`; otherwise behaves as NOP (see Configuration).
- `operands` always equals the captured `imem_data[11:0]`.
- `operands`, `alu_cmd` and `dst_in_sel` are registered and hold their last decoded values outside EXEC. `reg_wr_en` is 1 only during EXEC of a writing instruction.
- PC wrap-around: PC = 2^PC_W−1 increments to 0 with no flag.
- `start` is ignored in FETCH and EXEC.
- HALT: `start`=1 → FETCH, with PC=`RESET_PC` and `illegal` cleared.

## Timing
- Reset values:
  - state IDLE, PC=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `operands`=0, `alu_cmd`=`alu::ADD`, `ctrl_sig` all 0.
  - `busy`=0, `halted`=0, `illegal`=0.
- Assertion of `rst` clears all state immediately, including mid-FETCH. `imem_req` drops combinationally-free, i.e. as a register cleared by the async reset. Memory must discard a pending request.
- `start` high at edge n → `imem_req`=1 from cycle n+1.
- With `imem_ack` in the same cycle, EXEC occurs in cycle n+2 (`reg_wr_en`=1) and the next FETCH in n+3. Throughput is 2 cycles per instruction plus memory wait cycles.
- `DataPath` writes on the edge that ends EXEC. All outputs are register outputs; there are no combinational paths from inputs to outputs.
- `imem_ack` while `imem_req`=0 is ignored.

## Configuration
- `INSTR_CTRL_ILLEGAL_TRAP_EN`:
  - Defined: an undefined opcode sets `illegal`, suppresses `reg_wr_en`, and transitions EXEC → HALT, leaving PC at the offending address.
  - Undefined: an undefined opcode sets `illegal`, executes as NOP, and PC advances.

## Test plan
- Reset, then `start`; memory returns 0x1114 at addr 0 with zero wait → in EXEC: `operands`=0x114, `dst_in_sel`=1, `reg_wr_en`=1 for exactly 1 cycle; `imem_addr`=1 next FETCH.
- Program 0x1114, 0x130A, 0x2513, 0xF000 → three write pulses; third has `alu_cmd`=ADD, `operands`=0x513, `dst_in_sel`=0; `halted`=1 with PC=3.
- FETCH with `imem_ack` delayed 3 cycles → `imem_req` and `imem_addr` stable for 4 cycles; single EXEC follows; no write during wait.
- `PC_W`=2, four NOPs then 0xF000 at addr 0 on second lap → `imem_addr` sequence 0,1,2,3,0, then HALT.
- Opcode 0x7 at addr 0 → `illegal`=1; with macro: HALT, `reg_wr_en` never 1, `imem_addr` stays 0; without: NOP, fetch continues at 1.
- Assert `rst` during FETCH with `imem_req`=1 → `imem_req`=0 and all outputs at reset values before the next edge; `start` restarts at `RESET_PC`.
